mips_cpu_ifetch: RTL
====================

// Module: mips_cpu_ifetch
// PURPOSE
//  Instruction-fetch stage directly downstream of the program counter. Takes the PC value and issues one
//  Avalon-MM 32-bit read per instruction, then holds the fetched word until the decode/control logic acks it.
//  Detects the halt address, misaligned PCs and bus timeouts, and deasserts the CPU `active` flag on each.
// PARAMETERS
//  HALT_ADDR       32'h00000000  fetch of this PC halts the CPU instead of issuing a read
//  TIMEOUT_CYCLES  255           max consecutive waitrequest=1 cycles tolerated in READ (1..65535)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  pc_in          in   32  address of next instruction (PC stage output); sampled only in IDLE
//  fetch_en       in   1   request a fetch of pc_in; sampled only in IDLE
//  instr_ack      in   1   consumer has taken instr_out; honoured only when instr_valid=1
//  avm_address    out  32  Avalon read address (word aligned)
//  avm_read       out  1   Avalon read strobe
//  avm_byteenable out  4   always 4'b1111 while avm_read=1, else 4'b0000
//  avm_waitrequest in  1   slave stall; read accepted in cycle where avm_read=1 & avm_waitrequest=0
//  avm_readdata   in   32  read data, valid exactly one cycle after acceptance (read latency 1)
//  instr_out      out  32  fetched instruction word, stable while instr_valid=1
//  instr_valid    out  1   instr_out holds a new instruction
//  busy           out  1   1 in READ/RESP/VALID states
//  active         out  1   CPU running; 0 once HALTED
//  addr_err       out  1   sticky: misaligned PC fetch attempted
//  bus_err        out  1   sticky: waitrequest timeout
// BEHAVIOUR
//  Reset values: avm_address=0, avm_read=0, avm_byteenable=0, instr_out=0, instr_valid=0, busy=0,
//   active=1, addr_err=0, bus_err=0, wait counter=0, state=IDLE. All outputs registered.
//  FSM states IDLE, READ, RESP, VALID, HALTED:
//  - IDLE: fetch_en=0 -> stay. fetch_en=1: pc_in==HALT_ADDR -> HALTED (active<=0, no bus read);
//    else pc_in[1:0]!=0 -> HALTED (addr_err<=1, active<=0); else avm_address<=pc_in, avm_read<=1,
//    byteenable<=4'b1111, counter<=0 -> READ. Halt check has priority over alignment check.
//  - READ: address/read/byteenable held stable while waitrequest=1; counter increments each such cycle.
//    waitrequest=0 -> avm_read<=0, byteenable<=0 -> RESP. Counter reaching TIMEOUT_CYCLES while
//    waitrequest=1 -> avm_read<=0, bus_err<=1, active<=0 -> HALTED (read abandoned).
//  - RESP: instr_out<=avm_readdata (byte order per CONFIGURATION), instr_valid<=1 -> VALID.
//  - VALID: hold instr_out; instr_ack=1 -> instr_valid<=0 -> IDLE. No back-to-back issue from VALID.
//  - HALTED: terminal until rst; fetch_en, instr_ack, bus inputs ignored; avm_read=0.
//  Latency: fetch_en sampled at edge N, zero-wait slave -> avm_read high cycle N+1, instr_valid high N+3.
//  fetch_en outside IDLE ignored (no queueing). instr_ack outside VALID ignored.
//  Reset mid-operation (any state): next edge forces reset values; avm_read drops even if waitrequest=1;
//   a pending readdata beat after reset is discarded.
//  Counter width 16 bits; never wraps (saturates into HALTED).
// CONFIGURATION
//  IFETCH_BYTESWAP_EN defined: instr_out = {rd[7:0],rd[15:8],rd[23:16],rd[31:24]} (little-endian bus
//   to big-endian MIPS word). Undefined: instr_out = avm_readdata unchanged. No other behaviour differs.
// TESTING
//  1 rst, pc_in=32'hBFC00000, fetch_en=1, waitrequest=0, readdata=32'h2408000A next cycle
//    -> avm_read for 1 cycle at addr BFC00000, instr_valid at N+3 with 2408000A (0A000824 if BYTESWAP).
//  2 Same fetch, waitrequest=1 for 5 cycles -> avm_read/address stable 6 cycles, accepted on 6th,
//    instr_valid 2 cycles later; instr_out held until instr_ack, then instr_valid=0 and IDLE.
//  3 fetch_en=1, pc_in=32'h00000000 -> active=0 next cycle, avm_read never asserted, further fetch_en ignored.
//  4 fetch_en=1, pc_in=32'hBFC00002 -> addr_err=1, active=0, no read; reset -> addr_err=0, active=1.
//  5 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> avm_read drops after 4 stall cycles, bus_err=1, active=0.
//  6 rst asserted in READ with waitrequest=1 -> next cycle avm_read=0, instr_valid=0, state IDLE.

Source files
------------

// File: rtl/mips_cpu_ifetch_if.sv
// Bundle of request, Avalon-MM read master and status signals for the instruction-fetch stage.
// The master modport is the fetch stage; the slave modport is the PC/decode/memory side.
interface mips_cpu_ifetch_if;
    logic [31:0] pc_in;
    logic        fetch_en;
    logic        instr_ack;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        busy;
    logic        active;
    logic        addr_err;
    logic        bus_err;

    modport master (
        input  pc_in, fetch_en, instr_ack, avm_waitrequest, avm_readdata,
        output avm_address, avm_read, avm_byteenable,
        output instr_out, instr_valid, busy, active, addr_err, bus_err
    );

    modport slave (
        output pc_in, fetch_en, instr_ack, avm_waitrequest, avm_readdata,
        input  avm_address, avm_read, avm_byteenable,
        input  instr_out, instr_valid, busy, active, addr_err, bus_err
    );
endinterface

// File: rtl/mips_cpu_ifetch.sv
// MIPS instruction-fetch stage: one Avalon-MM read per fetch, word held until acked, halts on
// halt address / misaligned PC / waitrequest timeout. Define IFETCH_BYTESWAP_EN for a little-endian bus.
module mips_cpu_ifetch #(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    mips_cpu_ifetch_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RESP,
        S_VALID,
        S_HALTED
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state,    w_state_next;
    logic [31:0] r_addr,     w_addr_next;
    logic        r_read,     w_read_next;
    logic [3:0]  r_be,       w_be_next;
    logic [31:0] r_instr,    w_instr_next;
    logic        r_valid,    w_valid_next;
    logic        r_busy,     w_busy_next;
    logic        r_active,   w_active_next;
    logic        r_addr_err, w_addr_err_next;
    logic        r_bus_err,  w_bus_err_next;
    logic [15:0] r_wait_cnt, w_wait_cnt_next;
    logic [31:0] w_rd_word;

`ifdef IFETCH_BYTESWAP_EN
    assign w_rd_word = {bus.avm_readdata[7:0],   bus.avm_readdata[15:8],
                        bus.avm_readdata[23:16], bus.avm_readdata[31:24]};
`else
    assign w_rd_word = bus.avm_readdata;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_read_next     = r_read;
        w_be_next       = r_be;
        w_instr_next    = r_instr;
        w_valid_next    = r_valid;
        w_active_next   = r_active;
        w_addr_err_next = r_addr_err;
        w_bus_err_next  = r_bus_err;
        w_wait_cnt_next = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                if (bus.fetch_en) begin
                    // Halt address wins even if it also happens to be misaligned.
                    if (bus.pc_in == HALT_ADDR) begin
                        w_active_next = 1'b0;
                        w_state_next  = S_HALTED;
                    end else if (bus.pc_in[1:0] != 2'b00) begin
                        w_addr_err_next = 1'b1;
                        w_active_next   = 1'b0;
                        w_state_next    = S_HALTED;
                    end else begin
                        w_addr_next     = bus.pc_in;
                        w_read_next     = 1'b1;
                        w_be_next       = 4'b1111;
                        w_wait_cnt_next = 16'd0;
                        w_state_next    = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!bus.avm_waitrequest) begin
                    w_read_next  = 1'b0;
                    w_be_next    = 4'b0000;
                    w_state_next = S_RESP;
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_read_next    = 1'b0;
                    w_be_next      = 4'b0000;
                    w_bus_err_next = 1'b1;
                    w_active_next  = 1'b0;
                    w_state_next   = S_HALTED;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 16'd1;
                end
            end
            S_RESP: begin
                w_instr_next = w_rd_word;
                w_valid_next = 1'b1;
                w_state_next = S_VALID;
            end
            S_VALID: begin
                if (bus.instr_ack) begin
                    w_valid_next = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            S_HALTED: begin
                w_read_next = 1'b0;
                w_be_next   = 4'b0000;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next = (w_state_next == S_READ) || (w_state_next == S_RESP) ||
                      (w_state_next == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'd0;
            r_read     <= 1'b0;
            r_be       <= 4'b0000;
            r_instr    <= 32'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_active   <= 1'b1;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_read     <= w_read_next;
            r_be       <= w_be_next;
            r_instr    <= w_instr_next;
            r_valid    <= w_valid_next;
            r_busy     <= w_busy_next;
            r_active   <= w_active_next;
            r_addr_err <= w_addr_err_next;
            r_bus_err  <= w_bus_err_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    assign bus.avm_address    = r_addr;
    assign bus.avm_read       = r_read;
    assign bus.avm_byteenable = r_be;
    assign bus.instr_out      = r_instr;
    assign bus.instr_valid    = r_valid;
    assign bus.busy           = r_busy;
    assign bus.active         = r_active;
    assign bus.addr_err       = r_addr_err;
    assign bus.bus_err        = r_bus_err;
endmodule
